cpu_bus_master: RTL

CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

---
 rtl/cpu_bus_master.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cpu_bus_master.sv
// Single-master 68000-style asynchronous bus cycle engine: one command in, one
// strobed bus cycle out, terminated by DTACK, BERR or an internal wait-state timeout.
module cpu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic [15:0] rsp_rdata,
    output logic [22:0] ADDR,
    output logic        RW,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        DTACK,
    input  logic        BERR
);

    typedef enum logic [2:0] {StIdle, StAddr, StStrb, StWait, StRel} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [7:0]  cnt_q;
    logic        dtack_meta_q, dtack_sync_q, berr_meta_q, berr_sync_q;
    logic        req_ready_q, rsp_valid_q;
    logic [1:0]  rsp_status_q;
    logic [15:0] rsp_rdata_q;
    logic [22:0] addr_q;
    logic        rw_out_q, as_q, uds_q, lds_q, data_oe_q;
    logic [15:0] data_out_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dtack_meta_q <= 1'b1;
            dtack_sync_q <= 1'b1;
            berr_meta_q  <= 1'b1;
            berr_sync_q  <= 1'b1;
        end else begin
            dtack_meta_q <= DTACK;
            dtack_sync_q <= dtack_meta_q;
            berr_meta_q  <= BERR;
            berr_sync_q  <= berr_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            rw_q         <= 1'b1;
            be_q         <= 2'b00;
            cnt_q        <= 8'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'b00;
            rsp_rdata_q  <= 16'h0000;
            addr_q       <= 23'd0;
            rw_out_q     <= 1'b1;
            as_q         <= 1'b1;
            uds_q        <= 1'b1;
            lds_q        <= 1'b1;
            data_oe_q    <= 1'b0;
            data_out_q   <= 16'h0000;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        rw_q        <= req_rw;
                        be_q        <= req_be;
                        req_ready_q <= 1'b0;
                        if (req_be == 2'b00) begin
                            // No byte lanes selected: answer without touching the bus.
                            state_q      <= StRel;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= 2'b11;
                            rsp_rdata_q  <= 16'h0000;
                        end else begin
                            state_q    <= StAddr;
                            addr_q     <= req_addr;
                            rw_out_q   <= req_rw;
                            data_out_q <= req_wdata;
                            data_oe_q  <= ~req_rw;
                            cnt_q      <= 8'd0;
                        end
                    end
                end
                StAddr: begin
                    state_q <= StStrb;
                    as_q    <= 1'b0;
                    if (rw_q) begin
                        uds_q <= ~be_q[1];
                        lds_q <= ~be_q[0];
                    end
                end
                StStrb: begin
                    state_q <= StWait;
                    uds_q   <= ~be_q[1];
                    lds_q   <= ~be_q[0];
                end
                StWait: begin
                    if (!berr_sync_q || !dtack_sync_q || cnt_q == CntLast) begin
                        state_q     <= StRel;
                        as_q        <= 1'b1;
                        uds_q       <= 1'b1;
                        lds_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 16'h0000;
                        if (!berr_sync_q) begin
                            rsp_status_q <= 2'b01;
                        end else if (!dtack_sync_q) begin
                            rsp_status_q <= 2'b00;
                            if (rw_q) rsp_rdata_q <= DATA_IN;
                        end else begin
                            rsp_status_q <= 2'b10;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StRel: begin
                    state_q     <= StIdle;
                    data_oe_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign ADDR       = addr_q;
    assign RW         = rw_out_q;
    assign AS         = as_q;
    assign UDS        = uds_q;
    assign LDS        = lds_q;
    assign DATA_OUT   = data_out_q;
    assign DATA_OE    = data_oe_q;

endmodule
